// File: rtl/queue_drain_pkg.sv
// Shared types and default widths for the monitor event-queue drain.
//   state_t : drain controller states (IDLE, WAIT, HOLD)
//   elem_t  : one queue element at the default width (signed)
package queue_drain_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned CNT_W_DEF  = 64;
  localparam int unsigned STAT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef logic signed [DATA_W_DEF-1:0] elem_t;

endpackage

// File: rtl/queue_drain_if.sv
// Queue-side and downstream-side signals of the drain controller.
//   q_count     : queue occupancy (0 = empty)
//   q_pop       : one-cycle pop request to the queue
//   q_pop_valid : pop acknowledgement, one cycle after q_pop
//   q_data      : popped element, qualified by q_pop_valid
//   m_valid / m_ready / m_data : downstream valid/ready stream
// master = drain controller, slave = queue + downstream evaluator.
interface queue_drain_if
  import queue_drain_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
);

  logic [CNT_W-1:0]         q_count;
  logic                     q_pop;
  logic                     q_pop_valid;
  logic signed [DATA_W-1:0] q_data;
  logic                     m_valid;
  logic                     m_ready;
  logic signed [DATA_W-1:0] m_data;

  modport master (
    input  q_count, q_pop_valid, q_data, m_ready,
    output q_pop, m_valid, m_data
  );

  modport slave (
    output q_count, q_pop_valid, q_data, m_ready,
    input  q_pop, m_valid, m_data
  );

endinterface

// File: rtl/queue_drain_sat_counter.sv
// Saturating up-counter for monitor statistics.
//   clk, rst : clock, async active-high reset
//   inc      : count one event this cycle
//   count    : current count, holds at all-ones
//   sat      : registered flag, high once count has reached all-ones
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  // sat rises together with the final increment, so count never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc && !sat) begin
      count <= count + WIDTH'(1);
      sat   <= (count == (CNT_MAX - WIDTH'(1)));
    end
  end

endmodule

// File: rtl/queue_drain.sv
// Consumer-side controller for the monitor event queue: pops one element at
// a time, holds it for the downstream evaluator over valid/ready, flags pops
// the queue could not satisfy and counts delivered elements.
//   clk, rst  : clock, async active-high reset
//   en        : allow new pops
//   flush     : drop the held/in-flight element and return to idle
//   bus       : queue and downstream signals (queue_drain_if.master)
//   underflow : sticky, a pop came back without q_pop_valid
//   delivered : saturating count of downstream handshakes
module queue_drain
  import queue_drain_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned STAT_W = STAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  queue_drain_if.master     bus,
  output logic              underflow,
  output logic [STAT_W-1:0] delivered
);

  localparam logic [CNT_W-1:0] CNT_EMPTY = '0;

  state_t                   state;
  state_t                   state_nxt;
  logic                     pop_ok_c;
  logic                     q_pop_c;
  logic                     capture_c;
  logic                     release_c;
  logic                     handshake_c;
  logic                     underflow_set_c;
  logic                     m_valid_q;
  logic signed [DATA_W-1:0] m_data_q;
  logic                     delivered_sat;

  // q_count is only looked at in a cycle where a pop may be issued
  assign pop_ok_c = en && !flush && (bus.q_count != CNT_EMPTY);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle controls
  always_comb begin
    state_nxt       = state;
    q_pop_c         = 1'b0;
    capture_c       = 1'b0;
    release_c       = 1'b0;
    handshake_c     = 1'b0;
    underflow_set_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (pop_ok_c) begin
          q_pop_c   = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // en is ignored here so an issued pop always completes
        underflow_set_c = !bus.q_pop_valid;
        if (bus.q_pop_valid && !flush) begin
          capture_c = 1'b1;
          state_nxt = HOLD;
        end else begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (flush) begin
          release_c = 1'b1;
          state_nxt = IDLE;
        end else if (bus.m_ready) begin
          release_c   = 1'b1;
          handshake_c = 1'b1;
          // back-to-back pop in the handshake cycle
          if (pop_ok_c) begin
            q_pop_c   = 1'b1;
            state_nxt = WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Holding register and downstream valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      if (capture_c) begin
        m_valid_q <= 1'b1;
        m_data_q  <= bus.q_data;
      end else if (release_c) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  // Sticky underflow flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow <= 1'b0;
    end else if (underflow_set_c) begin
      underflow <= 1'b1;
    end
  end

  // Delivered-element statistic; stop feeding increments once saturated
  sat_counter #(
    .WIDTH (STAT_W)
  ) u_delivered (
    .clk   (clk),
    .rst   (rst),
    .inc   (handshake_c && !delivered_sat),
    .count (delivered),
    .sat   (delivered_sat)
  );

  assign bus.q_pop   = q_pop_c;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;

endmodule

// File: tb/tb_queue_drain.sv
// Bench for queue_drain: a queue model feeding the DUT, a transaction-level
// reference of the drain rules, a directed vector table, hand sequences for
// underflow/flush/reset, randomized traffic and a narrow-counter instance.
module tb_queue_drain;
  import queue_drain_pkg::*;

  localparam longint unsigned DELIV_MAX = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, en, flush;
  logic        underflow;
  logic [31:0] delivered;

  logic        rst_s, en_s, flush_s;
  logic        underflow_s;
  logic [2:0]  delivered_s;

  queue_drain_if #(.DATA_W(64), .CNT_W(64)) bus ();
  queue_drain_if #(.DATA_W(64), .CNT_W(64)) bus_s ();

  queue_drain #(.DATA_W(64), .CNT_W(64), .STAT_W(32)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .bus(bus),
    .underflow(underflow), .delivered(delivered)
  );

  queue_drain #(.DATA_W(64), .CNT_W(64), .STAT_W(3)) dut_s (
    .clk(clk), .rst(rst_s), .en(en_s), .flush(flush_s), .bus(bus_s),
    .underflow(underflow_s), .delivered(delivered_s)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // queue contents and fault injection
  longint q_mem[$];
  bit     force_invalid = 1'b0;
  bit     last_pop;

  // reference: an outstanding pop, an element held downstream, flags
  bit              r_pending, r_holding, r_uf;
  elem_t           r_data;
  longint unsigned r_deliv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  task automatic model_reset();
    r_pending = 0; r_holding = 0; r_uf = 0; r_data = '0; r_deliv = 0;
  endtask

  task automatic push(input longint v);
    q_mem.push_back(v);
    bus.q_count = 64'(q_mem.size());
  endtask

  task automatic clear_queue();
    q_mem.delete();
    bus.q_count = '0;
  endtask

  // One clock: check pop before the edge, advance the reference and the
  // queue model, check registered outputs just after the edge.
  task automatic tick();
    bit exp_pop;
    #3;
    exp_pop = !r_pending && en && !flush && (bus.q_count != 0) &&
              (!r_holding || bus.m_ready);
    check("q_pop", 64'(bus.q_pop), 64'(exp_pop));
    last_pop = bus.q_pop;
    if (r_pending) begin
      if (!bus.q_pop_valid) r_uf = 1;
      else if (!flush) begin r_holding = 1; r_data = bus.q_data; end
    end else if (r_holding) begin
      if (flush) r_holding = 0;
      else if (bus.m_ready) begin
        r_holding = 0;
        if (r_deliv != DELIV_MAX) r_deliv++;
      end
    end
    r_pending = exp_pop;
    @(posedge clk);
    #1;
    if (last_pop && !force_invalid && q_mem.size() > 0) begin
      bus.q_data      = q_mem.pop_front();
      bus.q_pop_valid = 1'b1;
    end else begin
      bus.q_data      = {$urandom, $urandom};
      bus.q_pop_valid = 1'b0;
    end
    bus.q_count = 64'(q_mem.size());
    check("m_valid",   64'(bus.m_valid), 64'(r_holding));
    check("m_data",    bus.m_data,       r_data);
    check("underflow", 64'(underflow),   64'(r_uf));
    check("delivered", 64'(delivered),   r_deliv);
  endtask

  typedef struct {
    bit     push_en;
    longint val;
    bit     en, flush, ready;
    bit     exp_pop, exp_valid;
    longint exp_data;
    int     exp_deliv;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit p, hs;

    rst = 1; en = 0; flush = 0;
    bus.q_count = '0; bus.q_pop_valid = 0; bus.q_data = '0; bus.m_ready = 0;
    rst_s = 1; en_s = 0; flush_s = 0;
    bus_s.q_count = 64'd1; bus_s.q_pop_valid = 0; bus_s.q_data = '0; bus_s.m_ready = 1;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid",   64'(bus.m_valid), 64'd0);
    check("rst_m_data",    bus.m_data,       64'd0);
    check("rst_underflow", 64'(underflow),   64'd0);
    check("rst_delivered", 64'(delivered),   64'd0);
    check("rst_q_pop",     64'(bus.q_pop),   64'd0);
    rst = 0;

    // single element, then en=0 with occupancy, then 2,3,4 under backpressure
    tbl[0]  = '{1, 1, 1, 0, 1, 1, 0, 0, 0};
    tbl[1]  = '{0, 0, 1, 0, 1, 0, 1, 1, 0};
    tbl[2]  = '{0, 0, 1, 0, 1, 0, 0, 1, 1};
    tbl[3]  = '{0, 0, 1, 0, 1, 0, 0, 1, 1};
    tbl[4]  = '{1, 2, 0, 0, 0, 0, 0, 1, 1};
    tbl[5]  = '{1, 3, 0, 0, 0, 0, 0, 1, 1};
    tbl[6]  = '{1, 4, 1, 0, 0, 1, 0, 1, 1};
    tbl[7]  = '{0, 0, 1, 0, 0, 0, 1, 2, 1};
    for (int i = 8; i <= 12; i++) tbl[i] = '{0, 0, 1, 0, 0, 0, 1, 2, 1};
    tbl[13] = '{0, 0, 1, 0, 1, 1, 0, 2, 2};
    tbl[14] = '{0, 0, 1, 0, 1, 0, 1, 3, 2};
    tbl[15] = '{0, 0, 1, 0, 1, 1, 0, 3, 3};
    tbl[16] = '{0, 0, 1, 0, 1, 0, 1, 4, 3};
    tbl[17] = '{0, 0, 1, 0, 1, 0, 0, 4, 4};

    foreach (tbl[i]) begin
      if (tbl[i].push_en) push(tbl[i].val);
      en = tbl[i].en; flush = tbl[i].flush; bus.m_ready = tbl[i].ready;
      tick();
      check($sformatf("vec%0d_pop", i),   64'(last_pop),    64'(tbl[i].exp_pop));
      check($sformatf("vec%0d_valid", i), 64'(bus.m_valid), 64'(tbl[i].exp_valid));
      check($sformatf("vec%0d_data", i),  bus.m_data,       tbl[i].exp_data);
      check($sformatf("vec%0d_deliv", i), 64'(delivered),   64'(tbl[i].exp_deliv));
    end

    // negative value keeps its sign across all 64 bits
    push(-5); en = 1; bus.m_ready = 0;
    tick(); tick();
    check("neg_valid", 64'(bus.m_valid), 64'd1);
    check("neg_data",  bus.m_data,       64'hFFFF_FFFF_FFFF_FFFB);
    bus.m_ready = 1;
    tick();
    check("neg_deliv", 64'(delivered), 64'd5);

    // pop answered without q_pop_valid
    force_invalid = 1; push(9); bus.m_ready = 0;
    tick(); tick();
    check("uf_set",   64'(underflow),   64'd1);
    check("uf_valid", 64'(bus.m_valid), 64'd0);
    check("uf_deliv", 64'(delivered),   64'd5);
    force_invalid = 0; clear_queue(); en = 0;
    repeat (3) tick();
    check("uf_sticky", 64'(underflow), 64'd1);

    // en dropped during WAIT still captures
    push(11); en = 1;
    tick();
    en = 0;
    tick();
    check("en_wait_valid", 64'(bus.m_valid), 64'd1);
    check("en_wait_data",  bus.m_data,       64'd11);

    // flush in HOLD beats a simultaneous handshake
    push(12); en = 1; flush = 1; bus.m_ready = 1;
    tick();
    check("flush_valid", 64'(bus.m_valid), 64'd0);
    check("flush_deliv", 64'(delivered),   64'd5);
    check("flush_nopop", 64'(last_pop),    64'd0);
    flush = 0; en = 0; clear_queue();
    tick();

    // async reset between edges while holding 7
    push(7); en = 1; bus.m_ready = 0;
    tick(); tick();
    check("pre_rst_data", bus.m_data, 64'd7);
    en = 0;
    #2 rst = 1;
    #1;
    check("arst_valid",     64'(bus.m_valid), 64'd0);
    check("arst_data",      bus.m_data,       64'd0);
    check("arst_underflow", 64'(underflow),   64'd0);
    check("arst_delivered", 64'(delivered),   64'd0);
    model_reset(); clear_queue(); bus.q_pop_valid = 0;
    @(posedge clk);
    #1;
    rst = 0; en = 1;
    tick();
    check("arst_nopop", 64'(last_pop), 64'd0);

    // randomized traffic against the reference
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0 && q_mem.size() < 8) push({$urandom, $urandom});
      en            = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 15) == 0);
      bus.m_ready   = ($urandom_range(0, 2) != 0);
      force_invalid = ($urandom_range(0, 19) == 0);
      tick();
    end
    en = 0; flush = 0; force_invalid = 0;

    // narrow delivered counter saturates at 7 after 9 handshakes
    rst_s = 0; en_s = 1;
    n = 0;
    for (int c = 0; c < 40 && n < 9; c++) begin
      #3;
      p  = bus_s.q_pop;
      hs = bus_s.m_valid && bus_s.m_ready;
      @(posedge clk);
      #1;
      bus_s.q_pop_valid = p;
      bus_s.q_data      = 64'(c);
      if (hs) begin
        n++;
        check("sat_step", 64'(delivered_s), 64'((n > 7) ? 7 : n));
      end
    end
    check("sat_handshakes", 64'(n), 64'd9);
    en_s = 0;
    repeat (4) @(posedge clk);
    #1;
    check("sat_final", 64'(delivered_s), 64'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/queue_drain.md
Name: queue_drain

Overview:
- Consumer-side controller for the monitor event queue.
- Watches queue occupancy and issues single-cycle pop requests.
- Captures the popped value and presents it to the downstream stream evaluator over a valid/ready handshake, one element at a time in FIFO order.
- Flags any pop the queue reports as invalid.

Parameters:
- DATA_W, 64, width of a queue element (signed).
- CNT_W, 64, width of the queue occupancy (cursor) input.
- STAT_W, 32, width of the delivered-element counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  enable; when low, no new pop is issued.
- flush  in  1  synchronous; discards the held element and returns to IDLE.
- q_count  in  CNT_W  queue occupancy (queue cursor); 0 = empty.
- q_pop  out  1  pop request to the queue, one-cycle pulse.
- q_pop_valid  in  1  queue's pop acknowledgement, valid the cycle after q_pop.
- q_data  in  DATA_W  popped element (signed), qualified by q_pop_valid.
- m_valid  out  1  downstream data valid.
- m_ready  in  1  downstream accepts when m_valid && m_ready at a rising edge.
- m_data  out  DATA_W  element presented downstream (signed).
- underflow  out  1  sticky; set when a pop was issued but q_pop_valid=0.
- delivered  out  STAT_W  count of completed m_valid&&m_ready handshakes; saturates at all-ones.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; q_pop=0, m_valid=0, m_data=0, underflow=0, delivered=0.
  - Any element in flight is lost.
- q_pop is combinational from state and inputs. m_data, m_valid, underflow and delivered are registered.
- State IDLE:
  - When en=1, flush=0 and q_count!=0: q_pop=1 for this cycle; next state WAIT.
  - Otherwise q_pop=0; stay in IDLE.
- State WAIT (one cycle; the queue responds one cycle after the pop):
  - q_pop=0. WAIT ignores en, so an issued pop always completes.
  - If q_pop_valid=1: m_data<=q_data, m_valid<=1, next HOLD.
  - If q_pop_valid=0: underflow<=1, m_data unchanged, m_valid stays 0, next IDLE.
  - If flush=1: the element is discarded (no capture, m_valid stays 0), next IDLE. Underflow is still checked.
- State HOLD:
  - m_valid=1. m_data is held stable until the handshake; the downstream may stall indefinitely.
  - On m_valid&&m_ready: delivered+=1 (saturating); m_valid<=0.
    - In the same cycle, if en=1, flush=0 and q_count!=0, q_pop=1 and next is WAIT (back-to-back).
    - Otherwise next is IDLE.
  - Without a handshake: stay in HOLD, q_pop=0.
  - flush=1 in HOLD: m_valid<=0, element dropped, no delivered increment even if m_ready=1, next IDLE.
- At most one element is outstanding or held, so the queue is never popped while m_valid=1 without a handshake.
- Peak throughput is 1 element per 2 cycles.
- q_count changes from concurrent pushes are tolerated. q_count is sampled only in the cycle q_pop is driven.
- A simultaneous push+pop at the queue is legal; the drain is unaffected.
- underflow clears only on rst. delivered holds at 2^STAT_W-1.
- Values pass through unmodified, sign preserved. No arithmetic on data.

Decomposition:
- Shared package:
  - state enum {IDLE, WAIT, HOLD} (2-bit encoding).
  - DATA_W, CNT_W and STAT_W defaults.
  - element type: signed [DATA_W-1:0].
- Sub-module sat_counter (width STAT_W, inc, sat) for delivered; reusable by other monitor statistics.
- FSM and holding register stay in queue_drain.

Test Plan:
- Single element: q_count=1, queue returns q_pop_valid=1, q_data=1 the cycle after q_pop, m_ready=1 → q_pop pulses once; m_valid=1 with m_data=1 for one cycle; delivered=1; back in IDLE.
- FIFO order with backpressure: queue holds 2,3,4 (q_count=3), m_ready=0 for 5 cycles then 1 → m_data=2 held stable for all stalled cycles; no q_pop while stalled; outputs 2,3,4 in order; delivered=3; each back-to-back pop follows its handshake by 0 cycles.
- Negative value and underflow: q_data=-5 popped → m_data=-5 (all 64 bits sign-extended). Next pop with q_pop_valid=0 → underflow=1 and stays 1; m_valid stays 0; delivered unchanged.
- Enable/flush: en=0 with q_count=2 → no q_pop. en dropped during WAIT → element still captured. flush=1 in HOLD with m_ready=1 → m_valid=0 next cycle, delivered not incremented.
- Async reset mid-HOLD (m_data=7, m_valid=1): rst asserted between edges → m_valid=0, m_data=0, underflow=0, delivered=0 immediately. After release with q_count=0 → no q_pop.
- Saturation (STAT_W=3 override): 9 handshakes → delivered=7.
